sa_rr_nx1: RTL and testbench

- N-requester, single-output switch allocator with round-robin priority.
- Generalises the 2-input allocator to parametrised N.
- Adds optional packet locking: the winner holds the output until it sends its tail beat, with an optional beat-count fairness bound.
- Sits at each router output port. Inputs are per-VC/per-input requests; ack is downstream readiness.

---
 rtl/sa_rr_nx1.sv | 104 ++++++++++
 tb/tb_sa_rr_nx1.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sa_rr_nx1.sv
// N-requester round-robin switch allocator for one router output port, with
// optional packet locking and an optional beat-count bound on a locked packet.
module sa_rr_nx1 #(
  parameter int N         = 4,
  parameter int LOCK_EN   = 1,
  parameter int MAX_BEATS = 0,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   tail,
  input  logic           ack,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           req_any,
  output logic           locked
);

  localparam int BW = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_owner;
  logic [BW-1:0]    r_beats;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_sel;
  logic             w_xfer;
  logic             w_tail;
  logic             w_beat_limit;
  logic [IDW-1:0]   w_ptr_next;

  // Circular scan starting at the priority pointer; the first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDW'((32'(r_ptr) + 32'(k)) % 32'(N));
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (r_state == LOCKED)
        grant[r_owner] = ack & req[r_owner];
      else if (w_found && ack)
        grant[w_win] = 1'b1;
    end
  end

  assign w_sel        = (r_state == LOCKED) ? r_owner : w_win;
  assign w_xfer       = |grant;
  assign w_tail       = tail[w_sel];
  assign grant_id     = w_xfer ? w_sel : '0;
  assign req_any      = |req;
  assign w_ptr_next   = (32'(w_sel) == 32'(N - 1)) ? '0 : w_sel + 1'b1;
  // Beat count after this transfer would reach the bound: release the output.
  assign w_beat_limit = (MAX_BEATS != 0) && ((32'(r_beats) + 32'd1) == 32'(MAX_BEATS));

  // Reset drops the lock indication in the same cycle, not one edge later.
  assign locked = (r_state == LOCKED) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_beats <= '0;
    end else if (w_xfer) begin
      if (r_state == IDLE) begin
        if (LOCK_EN == 0 || w_tail || MAX_BEATS == 1) begin
          r_ptr <= w_ptr_next;
        end else begin
          r_state <= LOCKED;
          r_owner <= w_win;
          r_beats <= BW'(1);
        end
      end else begin
        if (w_tail || w_beat_limit) begin
          r_state <= IDLE;
          r_ptr   <= w_ptr_next;
          r_beats <= '0;
        end else begin
          r_beats <= r_beats + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_rr_nx1.sv
// Directed bench for sa_rr_nx1: a vector table on the default build plus a
// hand sequence on a MAX_BEATS=2 build.
module tb_sa_rr_nx1;

  logic       clk;
  logic       rst,  rst2;
  logic [3:0] req,  req2;
  logic [3:0] tail, tail2;
  logic       ack,  ack2;
  logic [3:0] grant, grant2;
  logic [1:0] grant_id, grant_id2;
  logic       req_any, req_any2;
  logic       locked, locked2;

  int n_cmp = 0;
  int n_bad = 0;

  sa_rr_nx1 #(.N(4), .LOCK_EN(1), .MAX_BEATS(0)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .ack(ack),
    .grant(grant), .grant_id(grant_id), .req_any(req_any), .locked(locked)
  );

  sa_rr_nx1 #(.N(4), .LOCK_EN(1), .MAX_BEATS(2)) dut_mb2 (
    .clk(clk), .rst(rst2), .req(req2), .tail(tail2), .ack(ack2),
    .grant(grant2), .grant_id(grant_id2), .req_any(req_any2), .locked(locked2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] tail;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] id;
    logic       locked;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] tl,
                     input logic a, input logic [3:0] g, input logic [1:0] id,
                     input logic lk);
    vec_t v;
    v.rst = r; v.req = rq; v.tail = tl; v.ack = a;
    v.grant = g; v.id = id; v.locked = lk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step2(input logic [3:0] rq, input logic [3:0] tl,
                       input logic [3:0] g, input logic lk, input int idx);
    @(negedge clk);
    req2 = rq; tail2 = tl; ack2 = 1'b1; rst2 = 1'b0;
    #1;
    check("mb2_grant", idx, 32'(grant2), 32'(g));
    check("mb2_locked", idx, 32'(locked2), 32'(lk));
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; tail = 4'b0000; ack = 1'b1;
    rst2 = 1'b1; req2 = 4'b0000; tail2 = 4'b0000; ack2 = 1'b0;

    //   rst req      tail     ack grant    id    locked
    add(1, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0);
    add(1, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 2'd0, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0010, 2'd1, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 2'd2, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 2'd3, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 2'd0, 0);
    add(0, 4'b1000, 4'b1111, 1, 4'b1000, 2'd3, 0);
    add(0, 4'b0011, 4'b0000, 1, 4'b0001, 2'd0, 0);
    add(0, 4'b0011, 4'b0000, 1, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0001, 1, 4'b0001, 2'd0, 1);
    add(0, 4'b0011, 4'b0010, 1, 4'b0010, 2'd1, 0);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 0);
    add(0, 4'b1011, 4'b0000, 1, 4'b0000, 2'd0, 1);
    add(0, 4'b1011, 4'b0000, 1, 4'b0000, 2'd0, 1);
    add(0, 4'b1011, 4'b0000, 1, 4'b0000, 2'd0, 1);
    add(0, 4'b1111, 4'b0100, 1, 4'b0100, 2'd2, 1);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 2'd3, 0);
    add(0, 4'b0110, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0110, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0110, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0110, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 4'b0110, 4'b1111, 1, 4'b0010, 2'd1, 0);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 0);
    add(0, 4'b1111, 4'b0000, 0, 4'b0000, 2'd0, 1);
    add(0, 4'b1111, 4'b0000, 1, 4'b0100, 2'd2, 1);
    add(1, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'b0001, 2'd0, 0);
    add(0, 4'b1110, 4'b0000, 1, 4'b0000, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; tail = vecs[i].tail; ack = vecs[i].ack;
      #1;
      check("grant",    i, 32'(grant),    32'(vecs[i].grant));
      check("grant_id", i, 32'(grant_id), 32'(vecs[i].id));
      check("locked",   i, 32'(locked),   32'(vecs[i].locked));
      check("req_any",  i, 32'(req_any),  32'(|vecs[i].req));
      if (grant != 4'b0000)
        check("grant_in_req", i, 32'(grant & ~req), 32'd0);
    end

    // Forced release after two beats; requester 3 first gets the pointer.
    @(negedge clk);
    rst2 = 1'b1; ack2 = 1'b1; req2 = 4'b1001;
    #1;
    check("mb2_rst_grant", 0, 32'(grant2), 32'd0);
    step2(4'b0100, 4'b0100, 4'b0100, 1'b0, 1);
    step2(4'b1001, 4'b0000, 4'b1000, 1'b0, 2);
    step2(4'b1001, 4'b0000, 4'b1000, 1'b1, 3);
    step2(4'b1001, 4'b0000, 4'b0001, 1'b0, 4);
    step2(4'b1001, 4'b0000, 4'b0001, 1'b1, 5);
    step2(4'b1001, 4'b0000, 4'b1000, 1'b0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  always @(negedge clk) begin
    if (!$onehot0(grant)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL onehot0 grant=%b", grant);
    end
  end

endmodule
